// File: rtl/lcd_spi_rx.sv
// Panel-side receiver for the 4-wire display SPI bus: deserializes bytes, decodes CASET/RASET/RAMWR
// and emits RGB565 pixel writes with coordinates; status and counters sit on a small CPU bus.
module lcd_spi_rx #(
   parameter int H_RES = 240,
   parameter int V_RES = 135
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        spi_clk,
   input  logic        spi_cs,
   input  logic        spi_rs,
   input  logic        spi_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        pix_valid,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic [15:0] pix_data,
   input  logic        lcd_valid,
   output logic        lcd_ready,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic [31:0] rdata
);

   localparam logic [8:0] XE_RST = 9'(H_RES - 1);
   localparam logic [8:0] YE_RST = 9'(V_RES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CASET = 2'd1,
      S_RASET = 2'd2,
      S_RAMWR = 2'd3
   } state_t;

   state_t state, state_nxt;

   // {clk, cs, rs, data}; cs resets inactive so no frame error is flagged out of reset
   logic [3:0]  sync1, sync2;
   logic        sclk_d;
   logic        s_clk, s_cs, s_rs, s_dat, sclk_rise;

   logic [2:0]  bitcnt;
   logic [6:0]  shreg;
   logic        byte_done;
   logic [7:0]  byte_val;
   logic        byte_rs;
   logic        last_rs;

   logic [2:0]  pidx;
   logic        phase;
   logic [7:0]  hi_byte;
   logic [8:0]  xs, xe, ys, ye, x, y;
   logic [31:0] pix_cnt;
   logic [7:0]  frame_err;

   logic        is_cmd, is_dat, pix_fire, frame_inc;
   logic        bus_take, bus_wr, clr;
   logic [31:0] rd_mux;
   logic        unused_addr;

   assign s_clk     = sync2[3];
   assign s_cs      = sync2[2];
   assign s_rs      = sync2[1];
   assign s_dat     = sync2[0];
   assign sclk_rise = s_clk & ~sclk_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1  <= 4'b0100;
         sync2  <= 4'b0100;
         sclk_d <= 1'b0;
      end else begin
         sync1  <= {spi_clk, spi_cs, spi_rs, spi_data};
         sync2  <= sync1;
         sclk_d <= s_clk;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bitcnt    <= 3'd0;
         shreg     <= 7'd0;
         byte_done <= 1'b0;
         byte_val  <= 8'd0;
         byte_rs   <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (s_cs) begin
            bitcnt <= 3'd0;
         end else if (sclk_rise) begin
            shreg  <= {shreg[5:0], s_dat};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
               byte_done <= 1'b1;
               byte_val  <= {shreg, s_dat};
               byte_rs   <= s_rs;
            end
         end
      end
   end

   assign frame_inc = s_cs && (bitcnt != 3'd0);
   assign is_cmd    = byte_done & ~byte_rs;
   assign is_dat    = byte_done & byte_rs;
   assign pix_fire  = is_dat && (state == S_RAMWR) && phase;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (is_cmd) begin
         case (byte_val)
            8'h2A:   state_nxt = S_CASET;
            8'h2B:   state_nxt = S_RASET;
            8'h2C:   state_nxt = S_RAMWR;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Window registers keep only [8:0] of each 16-bit parameter; pidx parks at 4 after the fourth byte
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd_valid <= 1'b0;
         cmd_byte  <= 8'd0;
         pix_valid <= 1'b0;
         pix_x     <= 9'd0;
         pix_y     <= 9'd0;
         pix_data  <= 16'd0;
         last_rs   <= 1'b0;
         pidx      <= 3'd0;
         phase     <= 1'b0;
         hi_byte   <= 8'd0;
         xs        <= 9'd0;
         xe        <= XE_RST;
         ys        <= 9'd0;
         ye        <= YE_RST;
         x         <= 9'd0;
         y         <= 9'd0;
      end else begin
         cmd_valid <= 1'b0;
         pix_valid <= 1'b0;
         if (byte_done) last_rs <= byte_rs;
         if (is_cmd) begin
            cmd_valid <= 1'b1;
            cmd_byte  <= byte_val;
            pidx      <= 3'd0;
            phase     <= 1'b0;
            if (byte_val == 8'h2C) begin
               x <= xs;
               y <= ys;
            end
         end else if (is_dat) begin
            case (state)
               S_CASET: if (!pidx[2]) begin
                  case (pidx[1:0])
                     2'd0: xs[8]   <= byte_val[0];
                     2'd1: xs[7:0] <= byte_val;
                     2'd2: xe[8]   <= byte_val[0];
                     2'd3: xe[7:0] <= byte_val;
                     default: ;
                  endcase
                  pidx <= pidx + 3'd1;
               end
               S_RASET: if (!pidx[2]) begin
                  case (pidx[1:0])
                     2'd0: ys[8]   <= byte_val[0];
                     2'd1: ys[7:0] <= byte_val;
                     2'd2: ye[8]   <= byte_val[0];
                     2'd3: ye[7:0] <= byte_val;
                     default: ;
                  endcase
                  pidx <= pidx + 3'd1;
               end
               S_RAMWR: begin
                  if (!phase) begin
                     hi_byte <= byte_val;
                     phase   <= 1'b1;
                  end else begin
                     pix_valid <= 1'b1;
                     pix_data  <= {hi_byte, byte_val};
                     pix_x     <= x;
                     pix_y     <= y;
                     phase     <= 1'b0;
                     if (x == xe) begin
                        x <= xs;
                        y <= (y == ye) ? ys : y + 9'd1;
                     end else begin
                        x <= x + 9'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Bus handshake: a request is taken when lcd_valid=1 and lcd_ready=0; lcd_ready answers on the
   // next clk for exactly one cycle with rdata valid, and lcd_valid is ignored during that cycle.
   assign bus_take    = lcd_valid & ~lcd_ready;
   assign bus_wr      = |wstrb;
   assign clr         = bus_take && (wstrb == 4'hF) && (addr[7:0] == 8'h08) && (wdata == 32'hFFFF_FFFF);
   assign unused_addr = &{1'b0, addr[31:8]};

   always_comb begin
      rd_mux = 32'd0;
      case (addr[7:0])
         8'h00:   rd_mux = {23'd0, last_rs, cmd_byte};
         8'h04:   rd_mux = pix_cnt;
         8'h08:   rd_mux = {14'd0, state, 8'd0, frame_err};
         8'h0C:   rd_mux = {7'd0, xs, 7'd0, xe};
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lcd_ready <= 1'b0;
         rdata     <= 32'd0;
         pix_cnt   <= 32'd0;
         frame_err <= 8'd0;
      end else begin
         lcd_ready <= bus_take;
         rdata     <= (bus_take && !bus_wr) ? rd_mux : 32'd0;
         // Clear beats any increment landing on the same clk
         if (clr)           pix_cnt <= 32'd0;
         else if (pix_fire) pix_cnt <= pix_cnt + 32'd1;
         if (clr)                                 frame_err <= 8'd0;
         else if (frame_inc && frame_err != 8'hFF) frame_err <= frame_err + 8'd1;
      end
   end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Bench for lcd_spi_rx: directed vector table, hand-timed corner sequences and random byte traffic
// checked against a byte-level panel model.
`timescale 1ns/1ps
module tb_lcd_spi_rx;

   logic        clk = 1'b0;
   logic        resetn;
   logic        spi_clk, spi_cs, spi_rs, spi_data;
   logic        cmd_valid, pix_valid, lcd_valid, lcd_ready;
   logic [7:0]  cmd_byte;
   logic [8:0]  pix_x, pix_y;
   logic [15:0] pix_data;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  wstrb;

   lcd_spi_rx dut (
      .clk(clk), .resetn(resetn),
      .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_rs(spi_rs), .spi_data(spi_data),
      .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
      .lcd_valid(lcd_valid), .lcd_ready(lcd_ready), .addr(addr), .wdata(wdata),
      .wstrb(wstrb), .rdata(rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Scoreboard queues
   logic [7:0]  exp_cmd_q[$];
   logic [33:0] exp_pix_q[$];
   logic [7:0]  mon_cmd;
   logic [33:0] mon_pix;

   always @(negedge clk) begin
      if (resetn) begin
         if (cmd_valid) begin
            if (exp_cmd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL cmd_unexpected act=%h exp=none", cmd_byte);
            end else begin
               mon_cmd = exp_cmd_q.pop_front();
               chk("cmd_byte", 48'(cmd_byte), 48'(mon_cmd));
            end
         end
         if (pix_valid) begin
            if (exp_pix_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL pix_unexpected act=%h exp=none", {pix_x, pix_y, pix_data});
            end else begin
               mon_pix = exp_pix_q.pop_front();
               chk("pixel", 48'({pix_x, pix_y, pix_data}), 48'(mon_pix));
            end
         end
      end
   end

   // Panel model: window parameters kept as full 16-bit words {xs, xe, ys, ye}
   logic [15:0] m_word[4];
   int          m_state, m_pidx, m_phase, m_ferr;
   logic [7:0]  m_hi, m_cmd;
   logic        m_last_rs;
   logic [8:0]  m_x, m_y;
   logic [31:0] m_pix_cnt;

   task automatic model_reset();
      m_word = '{16'd0, 16'd239, 16'd0, 16'd134};
      m_state = 0; m_pidx = 0; m_phase = 0; m_ferr = 0;
      m_hi = 8'd0; m_cmd = 8'd0; m_last_rs = 1'b0;
      m_x = 9'd0; m_y = 9'd0; m_pix_cnt = 32'd0;
   endtask

   task automatic model_byte(input logic rs, input logic [7:0] b, input bit push);
      logic [8:0] xs, xe, ys, ye;
      int idx;
      m_last_rs = rs;
      xs = m_word[0][8:0]; xe = m_word[1][8:0];
      ys = m_word[2][8:0]; ye = m_word[3][8:0];
      if (!rs) begin
         if (push) exp_cmd_q.push_back(b);
         m_cmd = b; m_pidx = 0; m_phase = 0;
         if (b == 8'h2A)      m_state = 1;
         else if (b == 8'h2B) m_state = 2;
         else if (b == 8'h2C) begin m_state = 3; m_x = xs; m_y = ys; end
         else                 m_state = 0;
      end else if (m_state == 1 || m_state == 2) begin
         if (m_pidx < 4) begin
            idx = (m_state == 1 ? 0 : 2) + m_pidx / 2;
            if (m_pidx % 2 == 0) m_word[idx][15:8] = b;
            else                 m_word[idx][7:0]  = b;
            m_pidx++;
         end
      end else if (m_state == 3) begin
         if (m_phase == 0) begin
            m_hi = b; m_phase = 1;
         end else begin
            if (push) exp_pix_q.push_back({m_x, m_y, m_hi, b});
            m_pix_cnt = m_pix_cnt + 32'd1;
            m_phase = 0;
            if (m_x == xe) begin
               m_x = xs;
               m_y = (m_y == ye) ? ys : m_y + 9'd1;
            end else begin
               m_x = m_x + 9'd1;
            end
         end
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [7:0] a);
      case (a)
         8'h00:   return {23'd0, m_last_rs, m_cmd};
         8'h04:   return m_pix_cnt;
         8'h08:   return {14'd0, 2'(m_state), 8'd0, 8'(m_ferr)};
         8'h0C:   return {7'd0, m_word[0][8:0], 7'd0, m_word[1][8:0]};
         default: return 32'd0;
      endcase
   endfunction

   // SPI driver: each spi_clk phase lasts 3 clk
   task automatic spi_bit(input logic rs, input logic d);
      spi_rs = rs; spi_data = d;
      repeat (3) @(negedge clk);
      spi_clk = 1'b1;
      repeat (3) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic send_raw(input logic rs, input logic [7:0] b);
      @(negedge clk);
      spi_cs = 1'b0;
      for (int i = 7; i >= 0; i--) spi_bit(rs, b[i]);
      repeat (2) @(negedge clk);
      spi_cs = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_partial(input int nbits);
      @(negedge clk);
      spi_cs = 1'b0;
      for (int i = 0; i < nbits; i++) spi_bit(1'b1, 1'($urandom_range(0, 1)));
      repeat (2) @(negedge clk);
      spi_cs = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_cmd_q.size() != 0 || exp_pix_q.size() != 0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_cmd_q.size() != 0 || exp_pix_q.size() != 0) begin
         errors++;
         $display("FAIL drain act=%0d exp=0 pending events", exp_cmd_q.size() + exp_pix_q.size());
         exp_cmd_q.delete();
         exp_pix_q.delete();
      end
   endtask

   task automatic send_chk(input logic rs, input logic [7:0] b);
      model_byte(rs, b, 1'b1);
      send_raw(rs, b);
      drain();
   endtask

   task automatic send_exp(input logic rs, input logic [7:0] b);
      model_byte(rs, b, 1'b0);
      send_raw(rs, b);
      drain();
   endtask

   task automatic bus_xfer(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st,
                           output logic [31:0] d);
      int n = 0;
      @(negedge clk);
      lcd_valid = 1'b1; addr = {24'd0, a}; wdata = wd; wstrb = st;
      do begin
         @(negedge clk);
         n++;
      end while (!lcd_ready && n < 10);
      d = rdata;
      if (!lcd_ready) begin
         checks++; errors++;
         $display("FAIL bus_timeout act=0 exp=1 addr=%h", a);
      end
      lcd_valid = 1'b0; wstrb = 4'd0; wdata = 32'd0;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_xfer(a, 32'd0, 4'd0, d);
      chk(name, 48'(d), 48'(exp));
   endtask

   typedef struct {
      logic        rs;
      logic [7:0]  b;
      logic        ec;
      logic        ep;
      logic [8:0]  ex;
      logic [8:0]  ey;
      logic [15:0] ed;
   } vec_t;

   vec_t tbl[15];

   initial begin : watchdog
      #900us;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] d;
      logic [7:0]  b;
      int          r;

      tbl[0]  = '{1'b0, 8'h2A, 1'b1, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[2]  = '{1'b1, 8'h28, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[4]  = '{1'b1, 8'h17, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[5]  = '{1'b0, 8'h2B, 1'b1, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[7]  = '{1'b1, 8'h35, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[9]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[10] = '{1'b0, 8'h2C, 1'b1, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[11] = '{1'b1, 8'hF8, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 9'd40, 9'd53, 16'hF800};
      tbl[13] = '{1'b1, 8'h07, 1'b0, 1'b0, 9'd0,  9'd0,  16'h0000};
      tbl[14] = '{1'b1, 8'hE0, 1'b0, 1'b1, 9'd41, 9'd53, 16'h07E0};

      // Clock/reset
      resetn = 1'b0;
      spi_clk = 1'b0; spi_cs = 1'b1; spi_rs = 1'b0; spi_data = 1'b0;
      lcd_valid = 1'b0; addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
      model_reset();
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_cmd_valid", 48'(cmd_valid), 48'd0);
      chk("rst_cmd_byte",  48'(cmd_byte),  48'd0);
      chk("rst_pix_valid", 48'(pix_valid), 48'd0);
      chk("rst_pix_xy",    48'({pix_x, pix_y}), 48'd0);
      chk("rst_pix_data",  48'(pix_data),  48'd0);
      chk("rst_lcd_ready", 48'(lcd_ready), 48'd0);
      chk("rst_rdata",     48'(rdata),     48'd0);
      rd_chk("rst_rd08", 8'h08, 32'h0000_0000);
      rd_chk("rst_rd0c", 8'h0C, 32'h0000_00EF);
      rd_chk("rst_rd00", 8'h00, 32'h0000_0000);
      rd_chk("rst_rd04", 8'h04, 32'h0000_0000);
      @(negedge clk);
      chk("rdata_idle", 48'(rdata), 48'd0);

      // Directed window + two pixels
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].ec) exp_cmd_q.push_back(tbl[i].b);
         if (tbl[i].ep) exp_pix_q.push_back({tbl[i].ex, tbl[i].ey, tbl[i].ed});
         send_exp(tbl[i].rs, tbl[i].b);
      end
      rd_chk("win_rd0c", 8'h0C, 32'h0028_0117);
      rd_chk("win_rd04", 8'h04, 32'd2);
      rd_chk("win_rd08", 8'h08, 32'h0003_0000);
      rd_chk("win_rd00", 8'h00, 32'h0000_012C);

      // Single-column window, two rows: row wrap back to ys
      send_chk(1'b0, 8'h2A);
      send_chk(1'b1, 8'h00); send_chk(1'b1, 8'h05); send_chk(1'b1, 8'h00); send_chk(1'b1, 8'h05);
      send_chk(1'b0, 8'h2B);
      send_chk(1'b1, 8'h00); send_chk(1'b1, 8'h00); send_chk(1'b1, 8'h00); send_chk(1'b1, 8'h01);
      send_chk(1'b0, 8'h2C);
      send_exp(1'b1, 8'h12);
      exp_pix_q.push_back({9'd5, 9'd0, 16'h1234});
      send_exp(1'b1, 8'h34);
      send_exp(1'b1, 8'h56);
      exp_pix_q.push_back({9'd5, 9'd1, 16'h5678});
      send_exp(1'b1, 8'h78);
      send_exp(1'b1, 8'h9A);
      exp_pix_q.push_back({9'd5, 9'd0, 16'h9ABC});
      send_exp(1'b1, 8'hBC);
      rd_chk("wrap_rd04", 8'h04, 32'd5);

      // Counter clear landing on the same clk as a pixel completes
      send_chk(1'b1, 8'hAB);
      b = 8'hCD;
      model_byte(1'b1, b, 1'b1);
      m_pix_cnt = 32'd0;
      m_ferr = 0;
      @(negedge clk);
      spi_cs = 1'b0;
      for (int i = 7; i >= 1; i--) spi_bit(1'b1, b[i]);
      spi_rs = 1'b1; spi_data = b[0];
      repeat (3) @(negedge clk);
      spi_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      lcd_valid = 1'b1; addr = 32'h08; wstrb = 4'hF; wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      chk("clr_same_clk_pix", 48'(pix_valid), 48'd1);
      chk("clr_ready_high",   48'(lcd_ready), 48'd1);
      @(posedge clk);
      #1;
      chk("clr_ready_one_clk", 48'(lcd_ready), 48'd0);
      lcd_valid = 1'b0; wstrb = 4'd0; wdata = 32'd0;
      @(negedge clk);
      chk("clr_ready_stays_low", 48'(lcd_ready), 48'd0);
      spi_clk = 1'b0;
      repeat (2) @(negedge clk);
      spi_cs = 1'b1;
      drain();
      rd_chk("clr_rd04", 8'h04, 32'd0);

      // Partial frame then a short command
      send_partial(5);
      m_ferr = m_ferr + 1;
      send_chk(1'b0, 8'h11);
      rd_chk("ferr_rd08", 8'h08, 32'h0000_0001);
      rd_chk("ferr_rd00", 8'h00, 32'h0000_0011);

      // Writes with no effect
      bus_xfer(8'h04, 32'hFFFF_FFFF, 4'hF, d);
      bus_xfer(8'h08, 32'hFFFF_FFFF, 4'h1, d);
      bus_xfer(8'h08, 32'h0000_0001, 4'hF, d);
      rd_chk("nop_wr_rd08", 8'h08, model_rd(8'h08));
      rd_chk("unmapped_rd", 8'h40, 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            case ($urandom_range(0, 3))
               0:       b = 8'h2A;
               1:       b = 8'h2B;
               2:       b = 8'h2C;
               default: b = 8'($urandom_range(0, 255));
            endcase
            send_chk(1'b0, b);
         end else if (r == 2 && (i % 4) == 0) begin
            send_partial($urandom_range(1, 7));
            if (m_ferr < 255) m_ferr = m_ferr + 1;
         end else begin
            if (m_state == 1 || m_state == 2)
               b = (m_pidx % 2 == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 6));
            else
               b = 8'($urandom_range(0, 255));
            send_chk(1'b1, b);
         end
         if (i % 10 == 9) begin
            rd_chk("rnd_rd00", 8'h00, model_rd(8'h00));
            rd_chk("rnd_rd04", 8'h04, model_rd(8'h04));
            rd_chk("rnd_rd08", 8'h08, model_rd(8'h08));
            rd_chk("rnd_rd0c", 8'h0C, model_rd(8'h0C));
         end
      end

      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
